frac_mod_sequencer: RTL
=======================

Name: frac_mod_sequencer

Overview:
- First-order fractional-N sequencer for the dual-modulus frequency divider.
- Once per divider output cycle, it decides whether the next division is ÷240 or ÷248, and drives the modulus controller's select_in.
- Averaged over time, the division ratio equals 240 + 8·frac/2^ACC_W.
- Includes a shadowed, glitch-free fractional-word update handshake and optional LSB dither from an LFSR.

Parameters:
ACC_W, 16, accumulator and fractional-word width in bits (legal range 4..24)
LFSR_SEED, 15'h0001, reset value of the 15-bit dither LFSR (must be nonzero)

Ports:
clk  input  1  divided-clock tick; one rising edge per divider output cycle
rst_n  input  1  synchronous reset, active-low
en  input  1  1 = run sequencing; 0 = idle, fixed ÷240
frac_in  input  ACC_W  requested fractional word (unsigned)
frac_load  input  1  one-cycle request to latch frac_in into the shadow register
dither_en  input  1  1 = add LFSR bit to the accumulator LSB each RUN cycle
select_out  output  1  to divider select_in; 1 = ÷240, 0 = ÷248; registered
load_ack  output  1  one-cycle pulse: shadow word became the active word this edge
load_pending  output  1  shadow holds a word not yet applied
frac_active  output  ACC_W  fractional word currently in use
running  output  1  1 when FSM is in RUN

Behaviour:
- Clock and reset:
  - Single clock clk. All state changes on the rising edge.
  - Reset is synchronous: when rst_n=0 at an edge, all state is reset.
- Reset values:
  - Internal: state=IDLE, acc=0, shadow=0, lfsr=LFSR_SEED.
  - Outputs: select_out=1, load_ack=0, load_pending=0, frac_active=0, running=0.
- FSM states: IDLE and RUN.
  - IDLE→RUN on an edge with en=1.
  - RUN→IDLE on an edge with en=0.
  - running is 1 exactly when state is RUN.
- IDLE:
  - acc is held at 0; select_out=1; the LFSR is frozen.
  - Any pending or same-cycle load is applied at the next edge.
- RUN:
  - Arithmetic at each edge: sum = acc + frac_active + (dither_en ? lfsr[0] : 0), computed at ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0].
  - select_out <= ~sum[ACC_W]. A carry produces one ÷248 cycle; latency is 1 edge from the carry computation to select_out.
  - The LFSR advances one step per RUN edge only when dither_en=1. Polynomial x^15+x^14+1: shift left, new bit0 = b14^b13.
- Load handshake:
  - frac_load=1 at an edge: shadow <= frac_in; load_pending <= 1.
  - A second load while pending overwrites the shadow; only one ack is issued.
- Apply rule: frac_active <= shadow, load_pending <= 0, load_ack <= 1 for one cycle, on the first edge where load_pending=1 and any of these holds:
  - (a) state is IDLE or transitioning to IDLE;
  - (b) RUN and sum[ACC_W]=1 (apply on carry, so a ÷248 period is never split);
  - (c) RUN and frac_active=0.
- Simultaneous load and apply:
  - If frac_load=1 on the same edge as an apply, the apply uses the old shadow.
  - The new word is captured into the shadow; load_pending stays 1.
- Wrap-around:
  - The carry out of the accumulator is the only ÷248 trigger.
  - The sum never exceeds ACC_W+1 bits.
  - frac_active = 2^ACC_W−1 with dither adding 1 yields carry with acc unchanged; this is legal.
- Boundary values:
  - frac_active=0 with dither_en=0: select_out stays 1 permanently.
- en deassert mid-run:
  - At the next edge, acc is cleared and select_out=1; the active word is retained.
  - On re-entry to RUN, the accumulator starts from 0.
- Reset mid-operation overrides everything, including a pending load (which is discarded, no ack).

Test Plan:
- ACC_W=4, reset, load frac_in=4, en=1, dither_en=0 → load_ack pulses; select_out repeats 1,1,1,0 (one ÷248 per 4 cycles) for ≥16 cycles.
- ACC_W=4, frac=8 in RUN → select_out alternates 1,0,1,0. Then load frac_in=2 mid-sequence → load_pending=1 until the next carry edge; load_ack on that edge; pattern becomes one 0 per 8 cycles.
- ACC_W=4, frac=0, dither_en=0, RUN 100 cycles → select_out never 0. Load 5 → ack on the following edge (rule c).
- ACC_W=4, frac=0, dither_en=1 → first 0 on select_out occurs after the cumulative LFSR bit sum reaches 16; bench model matches cycle-exactly from LFSR_SEED.
- RUN with frac=4: drop en for 3 cycles with a load issued during IDLE, then reassert → immediate ack in IDLE; select_out=1 while idle; acc restarts at 0.
- rst_n=0 for 1 edge mid-RUN with load_pending=1 → all outputs at reset values next cycle; no load_ack; frac_active=0.

Source files
------------

// File: rtl/frac_mod_sequencer.sv
// First-order fractional-N sequencer: per divider output cycle, chooses /240 or /248
// from an accumulator carry, with a shadowed fractional word and optional LFSR dither.
module frac_mod_sequencer #(
    parameter int          ACC_W     = 16,
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] frac_in,
    input  logic             frac_load,
    input  logic             dither_en,
    output logic             select_out,
    output logic             load_ack,
    output logic             load_pending,
    output logic [ACC_W-1:0] frac_active,
    output logic             running
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] shadow_q;
    logic [ACC_W-1:0] frac_q;
    logic             pending_q;
    logic             ack_q;
    logic             sel_q;
    logic [14:0]      lfsr_q;
    logic [14:0]      lfsr_d;
    logic [ACC_W:0]   sum;
    logic             seq_active;
    logic             dither_bit;
    logic             carry;
    logic             apply;

    // Load handshake: frac_load is a single-cycle request with no back-pressure; the
    // word waits in the shadow (load_pending=1) and load_ack pulses on the edge it goes live.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        seq_active = (state_q == ST_RUN) && en;
        dither_bit = seq_active && dither_en && lfsr_q[0];
        sum        = {1'b0, acc_q} + {1'b0, frac_q} + {{ACC_W{1'b0}}, dither_bit};
        carry      = seq_active && sum[ACC_W];
        // Swapping on a carry edge keeps a /248 period from being split between two words.
        apply      = pending_q && (!seq_active || carry || (frac_q == '0));
        acc_d      = seq_active ? sum[ACC_W-1:0] : '0;
        lfsr_d     = lfsr_q;
        if (seq_active && dither_en) begin
            lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            shadow_q  <= '0;
            frac_q    <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            sel_q     <= 1'b1;
            lfsr_q    <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sel_q   <= ~carry;
            lfsr_q  <= lfsr_d;
            ack_q   <= apply;
            if (apply) begin
                frac_q <= shadow_q;
            end
            // A load coinciding with an apply lands in the shadow and stays pending.
            if (frac_load) begin
                shadow_q  <= frac_in;
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign select_out   = sel_q;
    assign load_ack     = ack_q;
    assign load_pending = pending_q;
    assign frac_active  = frac_q;
    assign running      = (state_q == ST_RUN);

endmodule
